// File: rtl/vip_stream_pkg.sv
// Shared definitions for the binary video stream blocks: FSM state
// encoding, memory word width and frame geometry helpers.
package vip_stream_pkg;

  // Width of one bitmap RAM word; bit 15 is the leftmost pixel.
  localparam int WORD_W = 16;

  // Frame source sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_VSYNC = 3'd1,
    ST_VBACK = 3'd2,
    ST_LINE  = 3'd3,
    ST_HBL   = 3'd4
  } state_t;

  // Clocks in one line period (active part plus horizontal blanking).
  function automatic int line_clks(input int hdisp, input int clken_div, input int h_blank);
    return hdisp * clken_div + h_blank;
  endfunction

  // Bitmap RAM words that make up one active line.
  function automatic int words_per_line(input int hdisp);
    return hdisp / WORD_W;
  endfunction

endpackage

// File: rtl/vip_word_shifter.sv
// Bitmap word fetch and pixel serialiser.
// Read port handshake: mem_rd_en is a one-cycle strobe with mem_addr valid in
// the same cycle; the RAM returns mem_rd_data exactly one cycle later, with no
// backpressure. The returned word lands in next_word and is moved into the
// shift register either at line start (load_first) or when the current word
// runs out (shift with word_end).
module vip_word_shifter
  import vip_stream_pkg::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              issue,
  input  logic              load_first,
  input  logic              shift,
  input  logic              word_end,
  input  logic [WORD_W-1:0] mem_rd_data,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              pix_bit
);

  logic [ADDR_W-1:0] rd_ptr;
  logic              rd_pend;
  logic [WORD_W-1:0] next_word;
  logic [WORD_W-1:0] shift_reg;

  // Read strobe/address generation; the pointer restarts at word 0 each frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      rd_ptr    <= '0;
      rd_pend   <= 1'b0;
    end else begin
      mem_rd_en <= issue;
      rd_pend   <= mem_rd_en;
      if (restart) begin
        rd_ptr <= '0;
      end else if (issue) begin
        mem_addr <= rd_ptr;
        rd_ptr   <= rd_ptr + 1'b1;
      end
    end
  end

  // Capture the returned word the cycle after the strobe was presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      next_word <= '0;
    end else if (rd_pend) begin
      next_word <= mem_rd_data;
    end
  end

  // MSB is the current pixel; shift left at the end of each pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
    end else if (load_first) begin
      shift_reg <= next_word;
    end else if (shift) begin
      shift_reg <= word_end ? next_word : {shift_reg[WORD_W-2:0], 1'b0};
    end
  end

  assign pix_bit = shift_reg[WORD_W-1];

endmodule

// File: rtl/vip_bin_frame_source.sv
// Binary frame replayer: walks a 1-bit bitmap in word-wide RAM and emits
// vsync/href/clken/Bit timing for the projection chain.
// The sequencer runs one cycle ahead of the pins: every output is a flop
// loaded from the current sequencer state, so all stream outputs, busy,
// frame_done and the RAM strobe share the same one-cycle offset.
// start is a one-cycle request honoured only in IDLE (no ready/ack; it is
// simply ignored while busy).
module vip_bin_frame_source
  import vip_stream_pkg::*;
#(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480,
  parameter int CLKEN_DIV = 2,
  parameter int H_BLANK   = 160,
  parameter int VS_PULSE  = 2,
  parameter int V_BACK    = 8,
  parameter int ADDR_W    = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  output logic              busy,
  output logic              frame_done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rd_data,
  output logic              post_frame_vsync,
  output logic              post_frame_href,
  output logic              post_frame_clken,
  output logic              post_img_Bit,
  output state_t            dbg_state
);

  localparam int LINE_CLKS      = line_clks(IMG_HDISP, CLKEN_DIV, H_BLANK);
  localparam int WORDS_PER_LINE = words_per_line(IMG_HDISP);
  localparam int VS_LEN         = VS_PULSE * LINE_CLKS;
  localparam int VB_LEN         = V_BACK * LINE_CLKS;
  localparam int HREF_LEN       = IMG_HDISP * CLKEN_DIV;
  localparam int MAX_A          = (VS_LEN > VB_LEN) ? VS_LEN : VB_LEN;
  localparam int MAX_B          = (HREF_LEN > H_BLANK) ? HREF_LEN : H_BLANK;
  localparam int CYC_MAX        = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CYC_W          = $clog2(CYC_MAX);
  localparam int X_W            = $clog2(IMG_HDISP);
  localparam int Y_W            = (IMG_VDISP > 1) ? $clog2(IMG_VDISP) : 1;
  localparam int P_W            = $clog2(CLKEN_DIV);

  localparam logic [CYC_W-1:0] VS_LAST    = CYC_W'(VS_LEN - 1);
  localparam logic [CYC_W-1:0] VB_LAST    = CYC_W'(VB_LEN - 1);
  localparam logic [CYC_W-1:0] VB_ISSUE   = CYC_W'(VB_LEN - 4);
  localparam logic [CYC_W-1:0] HREF_LAST  = CYC_W'(HREF_LEN - 1);
  localparam logic [CYC_W-1:0] HB_LAST    = CYC_W'(H_BLANK - 1);
  localparam logic [CYC_W-1:0] HB_ISSUE   = CYC_W'(H_BLANK - 4);
  localparam logic [X_W-1:0]   X_LAST     = X_W'(IMG_HDISP - 1);
  localparam logic [X_W-1:0]   X_LASTWORD = X_W'((WORDS_PER_LINE - 1) * WORD_W);
  localparam logic [Y_W-1:0]   Y_LAST     = Y_W'(IMG_VDISP - 1);
  localparam logic [P_W-1:0]   P_LAST     = P_W'(CLKEN_DIV - 1);

  state_t           state, state_nxt;
  logic [CYC_W-1:0] cyc_cnt, cyc_nxt;
  logic [P_W-1:0]   pix_div, pix_nxt;
  logic [X_W-1:0]   x_cnt, x_nxt;
  logic [Y_W-1:0]   y_cnt, y_nxt;
  logic             issue, load_first, shift, word_end, restart, frame_end;
  logic             pix_bit;

  assign dbg_state = state;

  // Sequencer state and position counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cyc_cnt <= '0;
      pix_div <= '0;
      x_cnt   <= '0;
      y_cnt   <= '0;
    end else begin
      state   <= state_nxt;
      cyc_cnt <= cyc_nxt;
      pix_div <= pix_nxt;
      x_cnt   <= x_nxt;
      y_cnt   <= y_nxt;
    end
  end

  // Next-state, counter advance and fetch/shift controls.
  always_comb begin
    state_nxt  = state;
    cyc_nxt    = cyc_cnt + 1'b1;
    pix_nxt    = pix_div;
    x_nxt      = x_cnt;
    y_nxt      = y_cnt;
    issue      = 1'b0;
    load_first = 1'b0;
    shift      = 1'b0;
    word_end   = 1'b0;
    restart    = 1'b0;
    frame_end  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cyc_nxt = '0;
        if (start) begin
          state_nxt = ST_VSYNC;
          restart   = 1'b1;
          pix_nxt   = '0;
          x_nxt     = '0;
          y_nxt     = '0;
        end
      end
      ST_VSYNC: begin
        if (cyc_cnt == VS_LAST) begin
          state_nxt = ST_VBACK;
          cyc_nxt   = '0;
        end
      end
      ST_VBACK: begin
        // First word of line 0 is fetched near the end of back porch.
        issue = (cyc_cnt == VB_ISSUE);
        if (cyc_cnt == VB_LAST) begin
          state_nxt  = ST_LINE;
          cyc_nxt    = '0;
          load_first = 1'b1;
        end
      end
      ST_LINE: begin
        // On the first pixel of a word, fetch the following word of this line.
        issue = (pix_div == '0) && (x_cnt[3:0] == 4'd0) && (x_cnt < X_LASTWORD);
        if (pix_div == P_LAST) begin
          shift    = 1'b1;
          word_end = (x_cnt[3:0] == 4'hF);
          pix_nxt  = '0;
          x_nxt    = (x_cnt == X_LAST) ? '0 : x_cnt + 1'b1;
        end else begin
          pix_nxt = pix_div + 1'b1;
        end
        if (cyc_cnt == HREF_LAST) begin
          state_nxt = ST_HBL;
          cyc_nxt   = '0;
        end
      end
      ST_HBL: begin
        // Prefetch the next line's first word; none after the last line.
        issue = (cyc_cnt == HB_ISSUE) && (y_cnt != Y_LAST);
        if (cyc_cnt == HB_LAST) begin
          cyc_nxt = '0;
          if (y_cnt != Y_LAST) begin
            state_nxt  = ST_LINE;
            y_nxt      = y_cnt + 1'b1;
            load_first = 1'b1;
          end else begin
            frame_end = 1'b1;
            if (continuous) begin
              state_nxt = ST_VSYNC;
              restart   = 1'b1;
              pix_nxt   = '0;
              x_nxt     = '0;
              y_nxt     = '0;
            end else begin
              state_nxt = ST_IDLE;
            end
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Registered stream and status outputs, decoded from the sequencer state.
  always_ff @(posedge clk) begin
    if (rst) begin
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
      post_img_Bit     <= 1'b0;
      busy             <= 1'b0;
      frame_done       <= 1'b0;
    end else begin
      post_frame_vsync <= (state == ST_VSYNC);
      post_frame_href  <= (state == ST_LINE);
      post_frame_clken <= (state == ST_LINE) && (pix_div == '0);
      post_img_Bit     <= (state == ST_LINE) && pix_bit;
      busy             <= (state != ST_IDLE);
      frame_done       <= frame_end;
    end
  end

  vip_word_shifter #(
    .ADDR_W(ADDR_W)
  ) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .restart    (restart),
    .issue      (issue),
    .load_first (load_first),
    .shift      (shift),
    .word_end   (word_end),
    .mem_rd_data(mem_rd_data),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .pix_bit    (pix_bit)
  );

endmodule

// File: tb/tb_vip_bin_frame_source.sv
// Bench for vip_bin_frame_source on a 32x4 frame (L = 72 clocks).
module tb_vip_bin_frame_source;
  import vip_stream_pkg::*;

  localparam int HD = 32;
  localparam int VD = 4;
  localparam int DIV = 2;
  localparam int HB = 8;
  localparam int AW = 15;
  localparam int L = 72;
  localparam int FRAME_LEN = 431;  // vsync rise to frame_done: 2*L + 4*L - 1

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic continuous = 1'b0;
  always #5 clk = ~clk;

  logic          busy, frame_done, mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_rd_data = 16'h0;
  logic          vsync, href, clken, pbit;
  state_t        dbg_state;

  vip_bin_frame_source #(
    .IMG_HDISP(HD), .IMG_VDISP(VD), .CLKEN_DIV(DIV), .H_BLANK(HB),
    .VS_PULSE(1), .V_BACK(1), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous),
    .busy(busy), .frame_done(frame_done), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .post_frame_vsync(vsync), .post_frame_href(href),
    .post_frame_clken(clken), .post_img_Bit(pbit), .dbg_state(dbg_state)
  );

  // Bitmap RAM model: one-cycle read latency.
  logic [15:0] mem [0:7];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr[2:0]];

  // ---------------- scoreboard ----------------
  logic [0:0]    exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [31:0]   exp_rows [0:3];
  int tests = 0;
  int fails = 0;
  logic sb_on = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_frame();
    for (int r = 0; r < VD; r++)
      for (int b = 31; b >= 0; b--) exp_q.push_back(exp_rows[r][b]);
    for (int a = 0; a < 8; a++) exp_addr_q.push_back(AW'(a));
  endtask

  // ---------------- monitor ----------------
  int tcyc = 0;
  always @(posedge clk) tcyc <= tcyc + 1;

  logic prev_vs = 1'b0, prev_href = 1'b0, prev_fd = 1'b0;
  int vs_rise_t = 0, href_rise_t = 0, last_clk_t = 0;
  int line_clk = 0, frame_pix = 0, frame_rd = 0, lines = 0;
  int clk_total = 0, rd_total = 0, fd_total = 0, href_total = 0, vs_total = 0, b2b_total = 0;
  int bit_low_viol = 0, clk_low_viol = 0, rd_vs_viol = 0, spacing_viol = 0, early_viol = 0;
  int last_frame_len = 0;
  logic [0:0]    e_bit;
  logic [AW-1:0] e_addr;

  always @(negedge clk) begin
    if (!rst) begin
      if (vsync && !prev_vs) begin
        vs_total++;
        vs_rise_t = tcyc;
        frame_pix = 0;
        frame_rd = 0;
        lines = 0;
        if (prev_fd) b2b_total++;
      end
      if (!vsync && prev_vs && sb_on) check("vsync_len", tcyc - vs_rise_t, L);
      if (href && !prev_href) begin
        if (lines == 0 && sb_on) check("vsync_to_href", tcyc - vs_rise_t, 2 * L);
        href_rise_t = tcyc;
        line_clk = 0;
        lines++;
        href_total++;
      end
      if (!href && prev_href && sb_on) begin
        check("href_len", tcyc - href_rise_t, HD * DIV);
        check("clkens_per_line", line_clk, HD);
      end
      if (!href && pbit) bit_low_viol++;
      if (!href && clken) clk_low_viol++;
      if (clken) begin
        if (line_clk > 0 && (tcyc - last_clk_t) != DIV) spacing_viol++;
        // The word holding this pixel must have been read in an earlier cycle.
        if (frame_rd <= frame_pix / 16) early_viol++;
        last_clk_t = tcyc;
        line_clk++;
        frame_pix++;
        clk_total++;
        if (sb_on) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL pixel_unexpected: got clken with Bit=%0d, expected no pixel", pbit);
          end else begin
            e_bit = exp_q.pop_front();
            check("pixel", int'(pbit), int'(e_bit));
          end
        end
      end
      if (mem_rd_en) begin
        rd_total++;
        frame_rd++;
        if (vsync) rd_vs_viol++;
        if (sb_on) begin
          if (exp_addr_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rd_unexpected: got read at addr %0d, expected none", mem_addr);
          end else begin
            e_addr = exp_addr_q.pop_front();
            check("rd_addr", int'(mem_addr), int'(e_addr));
          end
        end
      end
      if (frame_done) begin
        fd_total++;
        last_frame_len = tcyc - vs_rise_t;
      end
    end
    prev_vs = vsync;
    prev_href = href;
    prev_fd = frame_done;
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_fd(input string tag);
    int n;
    n = 0;
    while (frame_done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (frame_done !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: frame_done low after %0d cycles, expected pulse", tag, n);
    end
  endtask

  task automatic wait_href(input int count, input string tag);
    int n, seen;
    logic p;
    n = 0;
    seen = 0;
    p = href;
    while (seen < count && n < 3000) begin
      @(negedge clk);
      if (href && !p) seen++;
      p = href;
      n++;
    end
    if (seen < count) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: %0d href rises seen, expected %0d", tag, seen, count);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_vsync"}, int'(vsync), 0);
    check({tag, "_href"}, int'(href), 0);
    check({tag, "_clken"}, int'(clken), 0);
    check({tag, "_bit"}, int'(pbit), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
    check({tag, "_rd_en"}, int'(mem_rd_en), 0);
    check({tag, "_state"}, int'(dbg_state), int'(ST_IDLE));
  endtask

  int s_fd, s_href, s_clk, s_rd, s_vs, s_b2b;
  task automatic snap();
    s_fd = fd_total; s_href = href_total; s_clk = clk_total;
    s_rd = rd_total; s_vs = vs_total; s_b2b = b2b_total;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    mem[0] = 16'h8001; mem[1] = 16'hFFFF; mem[2] = 16'h0000; mem[3] = 16'h0000;
    mem[4] = 16'hA5A5; mem[5] = 16'h5A5A; mem[6] = 16'hFFFF; mem[7] = 16'h0001;
    // Hand-derived line patterns, leftmost pixel in bit 31.
    exp_rows[0] = 32'b1000_0000_0000_0001_1111_1111_1111_1111;
    exp_rows[1] = 32'b0000_0000_0000_0000_0000_0000_0000_0000;
    exp_rows[2] = 32'b1010_0101_1010_0101_0101_1010_0101_1010;
    exp_rows[3] = 32'b1111_1111_1111_1111_0000_0000_0000_0001;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    check("reset_addr", int'(mem_addr), 0);
    rst = 1'b0;

    // Single frame.
    sb_on = 1'b1;
    push_frame();
    snap();
    pulse_start();
    wait_fd("single");
    @(negedge clk);
    #1;
    check("single_busy_after", int'(busy), 0);
    check("single_state_after", int'(dbg_state), int'(ST_IDLE));
    check("single_frames", fd_total - s_fd, 1);
    check("single_lines", href_total - s_href, VD);
    check("single_clkens", clk_total - s_clk, VD * HD);
    check("single_reads", rd_total - s_rd, 8);
    check("single_frame_len", last_frame_len, FRAME_LEN);
    check("single_pix_left", exp_q.size(), 0);
    check("single_addr_left", exp_addr_q.size(), 0);

    // Continuous: start and continuous together, drop continuous in line 2 of frame 2.
    push_frame();
    push_frame();
    snap();
    continuous = 1'b1;
    pulse_start();
    wait_fd("cont1");
    @(negedge clk);
    check("cont_vsync_after_done", int'(vsync), 1);
    check("cont_busy_after_done", int'(busy), 1);
    wait_href(3, "cont_line2");
    continuous = 1'b0;
    wait_fd("cont2");
    @(negedge clk);
    #1;
    check("cont_busy_after", int'(busy), 0);
    check("cont_frames", fd_total - s_fd, 2);
    check("cont_back_to_back", b2b_total - s_b2b, 1);
    check("cont_reads", rd_total - s_rd, 16);
    check("cont_clkens", clk_total - s_clk, 2 * VD * HD);
    check("cont_pix_left", exp_q.size(), 0);

    // start while busy must not disturb the frame.
    push_frame();
    snap();
    pulse_start();
    wait_href(2, "busy_start");
    repeat (5) @(negedge clk);
    pulse_start();
    wait_fd("busy_start");
    repeat (200) @(negedge clk);
    #1;
    check("busy_start_frame_len", last_frame_len, FRAME_LEN);
    check("busy_start_frames", fd_total - s_fd, 1);
    check("busy_start_vsyncs", vs_total - s_vs, 1);
    check("busy_start_state", int'(dbg_state), int'(ST_IDLE));

    // Reset in line 1 at pixel 10.
    sb_on = 1'b0;
    pulse_start();
    wait_href(2, "rst_line1");
    begin
      int n, k;
      n = 1;
      k = 0;
      while (n < 11 && k < 200) begin
        @(negedge clk);
        if (clken) n++;
        k++;
      end
      check("rst_pixel10_reached", n, 11);
    end
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("midrst");
    rst = 1'b0;
    snap();
    repeat (300) @(negedge clk);
    #1;
    check("midrst_no_reads", rd_total - s_rd, 0);
    check("midrst_no_vsync", vs_total - s_vs, 0);
    check("midrst_state", int'(dbg_state), int'(ST_IDLE));

    // Whole-run invariants.
    check("bit_while_href_low", bit_low_viol, 0);
    check("clken_while_href_low", clk_low_viol, 0);
    check("read_during_vsync", rd_vs_viol, 0);
    check("clken_spacing", spacing_viol, 0);
    check("read_before_pixel", early_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
